// File: rtl/bp_if_queue_pkg.sv
// Shared constants and types for the BP->IF decoupling queue.
package bp_if_queue_pkg;

  localparam int unsigned BPQ_ADDR_WIDTH = 32;
  localparam int unsigned BPQ_GHR_WIDTH  = 5;
  localparam int unsigned BPQ_DEPTH      = 4;
  localparam int unsigned BPQ_PTR_WIDTH  = 2;

  // Entry layout at the default widths; field order is the packing order.
  typedef struct packed {
    logic                      taken;
    logic [BPQ_GHR_WIDTH-1:0]  pht_index;
    logic [BPQ_ADDR_WIDTH-1:0] next_pc;
    logic [BPQ_ADDR_WIDTH-1:0] current_pc;
  } bpq_entry_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/bp_if_queue_if.sv
// Handshake bundle between branch prediction (master side) and the queue (slave side).
interface bp_if_queue_if
  import bp_if_queue_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = BPQ_ADDR_WIDTH,
  parameter int unsigned GHR_WIDTH  = BPQ_GHR_WIDTH,
  parameter int unsigned PTR_WIDTH  = BPQ_PTR_WIDTH
);

  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_taken;
  logic [GHR_WIDTH-1:0]  in_pht_index;
  logic [ADDR_WIDTH-1:0] in_next_pc;
  logic [ADDR_WIDTH-1:0] in_current_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_taken;
  logic [GHR_WIDTH-1:0]  out_pht_index;
  logic [ADDR_WIDTH-1:0] out_next_pc;
  logic [ADDR_WIDTH-1:0] out_current_pc;
  logic [PTR_WIDTH:0]    occupancy;

  modport master (
    output flush, in_valid, in_taken, in_pht_index, in_next_pc, in_current_pc, out_ready,
    input  in_ready, out_valid, out_taken, out_pht_index, out_next_pc, out_current_pc, occupancy
  );

  modport slave (
    input  flush, in_valid, in_taken, in_pht_index, in_next_pc, in_current_pc, out_ready,
    output in_ready, out_valid, out_taken, out_pht_index, out_next_pc, out_current_pc, occupancy
  );

endinterface

// File: rtl/bp_if_queue_ring_ptr.sv
// Wrapping pointer for the queue ring; clear takes priority over increment.
module bp_if_queue_ring_ptr #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_ptr
);

  logic [WIDTH-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + WIDTH'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/bp_if_queue.sv
// DEPTH-entry FIFO decoupling branch prediction from instruction fetch.
// Status and head data are combinational views of registered state; no empty bypass.
module bp_if_queue
  import bp_if_queue_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = BPQ_ADDR_WIDTH,
  parameter int unsigned GHR_WIDTH  = BPQ_GHR_WIDTH,
  parameter int unsigned DEPTH      = BPQ_DEPTH,
  parameter int unsigned PTR_WIDTH  = BPQ_PTR_WIDTH
) (
  input logic          clk,
  input logic          rst,
  bp_if_queue_if.slave bus
);

  localparam int unsigned ENTRY_WIDTH = 1 + GHR_WIDTH + 2 * ADDR_WIDTH;
  localparam int unsigned CNT_WIDTH   = PTR_WIDTH + 1;

  if ((int'(PTR_WIDTH) != $clog2(DEPTH)) || !is_pow2(DEPTH)) begin : g_param_check
    $error("bp_if_queue: DEPTH must be a power of two >= 2 and PTR_WIDTH must equal $clog2(DEPTH)");
  end

  logic [ENTRY_WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_WIDTH-1:0]   r_count;
  logic [PTR_WIDTH-1:0]   w_wr_ptr;
  logic [PTR_WIDTH-1:0]   w_rd_ptr;
  logic [ENTRY_WIDTH-1:0] w_head;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;

  assign w_full  = (r_count == CNT_WIDTH'(DEPTH));
  assign w_empty = (r_count == '0);

  // A full queue refuses a push even when the head is popped in the same cycle.
  assign w_push = bus.in_valid & ~w_full & ~bus.flush;
  assign w_pop  = ~w_empty & bus.out_ready & ~bus.flush;

  bp_if_queue_ring_ptr #(.WIDTH(PTR_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_push),
    .i_clr (bus.flush),
    .o_ptr (w_wr_ptr)
  );

  bp_if_queue_ring_ptr #(.WIDTH(PTR_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_pop),
    .i_clr (bus.flush),
    .o_ptr (w_rd_ptr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (bus.flush) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + CNT_WIDTH'(1);
    end else if (w_pop && !w_push) begin
      r_count <= r_count - CNT_WIDTH'(1);
    end
  end

  // Storage survives a flush; only the pointers and count are cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[w_wr_ptr] <= {bus.in_taken, bus.in_pht_index, bus.in_next_pc, bus.in_current_pc};
    end
  end

  assign w_head = r_mem[w_rd_ptr];

  assign bus.in_ready  = ~w_full;
  assign bus.out_valid = ~w_empty;
  assign bus.occupancy = r_count;
  assign {bus.out_taken, bus.out_pht_index, bus.out_next_pc, bus.out_current_pc} = w_head;

endmodule
